result_ram: RTL and testbench

- Single-port result memory for the NPU datapath: stores 32-bit result words written by the compute pipeline.
- Readback is combinational for the host and the export logic.
- Storage is a flat register array named RAM. Simulation dumps it hierarchically with $writememh, so the name and shape are fixed.
- Adds per-entry written flags and a write counter so software can tell how many results have landed.

---
 rtl/result_ram_pkg.sv | 11 +
 rtl/result_ram_tracker.sv | 55 +++++
 rtl/result_ram.sv | 73 +++++++
 tb/tb_result_ram.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/result_ram_pkg.sv
// rtl/result_ram_pkg.sv - shared widths and types for the result memory
package result_ram_pkg;

    localparam int RES_DATA_W = 32;
    localparam int RES_ADDR_W = 6;
    localparam int RES_DEPTH  = 64;

    typedef logic [RES_DATA_W-1:0] res_word_t;
    typedef logic [RES_ADDR_W-1:0] res_addr_t;

endpackage

// File: rtl/result_ram_tracker.sv
// rtl/result_ram_tracker.sv - per-entry written flags, distinct-write counter and full flag
module result_ram_tracker
    import result_ram_pkg::*;
#(
    parameter int ADDR_W = RES_ADDR_W,
    parameter int DEPTH  = RES_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_fire,
    input  logic              in_range,
    input  logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic [ADDR_W:0]   wr_count,
    output logic              full
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] written_q, written_d;
    logic [ADDR_W:0]  count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
            count_q   <= '0;
        end else begin
            written_q <= written_d;
            count_q   <= count_d;
        end
    end

    // Only a first write to an entry advances the count; rewrites leave it alone.
    always_comb begin
        written_d = written_q;
        count_d   = count_q;
        if (clr) begin
            written_d = '0;
            count_d   = '0;
        end else if (wr_fire) begin
            written_d[addr] = 1'b1;
            if (!written_q[addr]) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_comb begin
        valid    = in_range && written_q[addr];
        wr_count = count_q;
        full     = (count_q == DEPTH_C);
    end

endmodule

// File: rtl/result_ram.sv
// rtl/result_ram.sv - single-port result memory with combinational readback and write tracking
// Optional synchronous flag/counter clear port enabled by RESULT_RAM_CLEAR_EN.
module result_ram
    import result_ram_pkg::*;
#(
    parameter int DATA_W = RES_DATA_W,
    parameter int ADDR_W = RES_ADDR_W,
    parameter int DEPTH  = RES_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
`ifdef RESULT_RAM_CLEAR_EN
    input  logic              clr,
`endif
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W:0]   wr_count,
    output logic              full
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // Name and shape are referenced hierarchically by the simulation dump.
    logic [DATA_W-1:0] RAM [0:DEPTH-1];

    logic in_range;
    logic wr_fire;
    logic clr_i;

`ifdef RESULT_RAM_CLEAR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    always_comb begin
        in_range = ({1'b0, addr} < DEPTH_C);
        wr_fire  = we && in_range && !clr_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                RAM[i] <= '0;
            end
        end else if (wr_fire) begin
            RAM[addr] <= din;
        end
    end

    always_comb begin
        dout = in_range ? RAM[addr] : '0;
    end

    result_ram_tracker #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_i),
        .wr_fire  (wr_fire),
        .in_range (in_range),
        .addr     (addr),
        .valid    (dout_valid),
        .wr_count (wr_count),
        .full     (full)
    );

endmodule

// File: tb/tb_result_ram.sv
// tb/tb_result_ram.sv - directed and randomized checks of result_ram against an array model
module tb_result_ram;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] din;
    logic        clr_s;
    logic [31:0] dout;
    logic        dout_valid;
    logic [6:0]  wr_count;
    logic        full;

    int n_cmp;
    int n_fail;

    logic [31:0] m_mem [64];
    bit          m_wr  [64];

    result_ram dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .addr       (addr),
        .din        (din),
`ifdef RESULT_RAM_CLEAR_EN
        .clr        (clr_s),
`endif
        .dout       (dout),
        .dout_valid (dout_valid),
        .wr_count   (wr_count),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 64; i++) if (m_wr[i]) c++;
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_mem[i] = '0;
            m_wr[i]  = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [5:0] a);
        check({tag, ".dout"},  dout,              m_mem[a]);
        check({tag, ".valid"}, {31'd0, dout_valid}, {31'd0, m_wr[a]});
        check({tag, ".count"}, {25'd0, wr_count}, 32'(m_count()));
        check({tag, ".full"},  {31'd0, full},     {31'd0, (m_count() == 64)});
    endtask

    // One clocked operation: check the pre-edge view, update the model, check the post-edge view.
    task automatic op(input string tag, input logic w, input logic [5:0] a,
                      input logic [31:0] d, input logic c);
        @(negedge clk);
        we = w; addr = a; din = d; clr_s = c;
        #1;
        check_all({tag, ".pre"}, a);
        @(posedge clk);
        if (c) begin
            for (int i = 0; i < 64; i++) m_wr[i] = 1'b0;
        end else if (w) begin
            m_mem[a] = d;
            m_wr[a]  = 1'b1;
        end
        #1;
        check_all({tag, ".post"}, a);
    endtask

    task automatic peek(input string tag, input logic [5:0] a);
        @(negedge clk);
        we = 1'b0; addr = a; clr_s = 1'b0;
        #1;
        check_all(tag, a);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; we = 1'b0; addr = '0; din = '0; clr_s = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_held.dout",  dout, 32'd0);
        check("rst_held.valid", {31'd0, dout_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 64; a++) begin
            addr = 6'(a);
            #1;
            check("sweep.dout",  dout, 32'd0);
            check("sweep.valid", {31'd0, dout_valid}, 32'd0);
            check("sweep.count", {25'd0, wr_count}, 32'd0);
            check("sweep.full",  {31'd0, full}, 32'd0);
        end

        op("wr0", 1'b1, 6'd0, 32'hDEADBEEF, 1'b0);
        op("wr1", 1'b1, 6'd1, 32'h12345678, 1'b0);
        peek("rd0", 6'd0);
        check("rd0.const", dout, 32'hDEADBEEF);
        peek("rd1", 6'd1);
        check("rd1.const", dout, 32'h12345678);
        check("rd1.count2", {25'd0, wr_count}, 32'd2);

        @(negedge clk);
        we = 1'b1; addr = 6'd0; din = 32'hCAFEF00D;
        #1;
        check("rewr.before", dout, 32'hDEADBEEF);
        @(posedge clk);
        m_mem[0] = 32'hCAFEF00D;
        #1;
        check("rewr.after", dout, 32'hCAFEF00D);
        check("rewr.count", {25'd0, wr_count}, 32'd2);
        check("rewr.valid", {31'd0, dout_valid}, 32'd1);

`ifdef RESULT_RAM_CLEAR_EN
        op("clr", 1'b1, 6'd5, 32'h1, 1'b1);
        check("clr.count", {25'd0, wr_count}, 32'd0);
        check("clr.ram5", dout, 32'd0);
        peek("clr.rd1", 6'd1);
        check("clr.rd1.dout", dout, 32'h12345678);
        check("clr.rd1.valid", {31'd0, dout_valid}, 32'd0);
`endif

        for (int a = 0; a < 64; a++) op("fill", 1'b1, 6'(a), 32'(a * 3), 1'b0);
        check("fill.full",  {31'd0, full}, 32'd1);
        check("fill.count", {25'd0, wr_count}, 32'd64);
        peek("fill.rd63", 6'd63);
        check("fill.rd63.const", dout, 32'd189);
        op("full.ovw", 1'b1, 6'd10, 32'hA5A5A5A5, 1'b0);
        check("full.ovw.const", dout, 32'hA5A5A5A5);

        // Async reset mid-write; the model restarts empty, then random traffic.
        @(negedge clk);
        we = 1'b1; addr = 6'd7; din = 32'h55AA55AA;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.dout",  dout, 32'd0);
        check("arst.valid", {31'd0, dout_valid}, 32'd0);
        check("arst.count", {25'd0, wr_count}, 32'd0);
        check("arst.full",  {31'd0, full}, 32'd0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;
        peek("arst.lost", 6'd7);

        for (int i = 0; i < 300; i++) begin
            logic        w;
            logic        c;
            logic [5:0]  a;
            w = ($urandom_range(0, 3) != 0);
            a = 6'($urandom_range(0, 63));
`ifdef RESULT_RAM_CLEAR_EN
            c = ($urandom_range(0, 40) == 0);
`else
            c = 1'b0;
`endif
            op("rand", w, a, $urandom, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
